// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage: FETCH -> EXEC -> (FETCH | HALT).
// Optional macro HALT_RESUME_EN adds a run input that resumes from HALT.
module fetch_unit #(
    parameter int unsigned AW = 16,
    parameter int unsigned IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] o,
    output logic          inst_vld,
    output logic [AW-1:0] pc,
    input  logic          h,
    input  logic          pcwe,
    input  logic          pcs,
    input  logic [AW-1:0] jt,
    output logic          halted,
    output logic [15:0]   icnt
`ifdef HALT_RESUME_EN
    ,
    input  logic          run
`endif
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [CW-1:0] icnt_q, icnt_d;

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            icnt_q  <= icnt_d;
        end
    end

    // Next-state and PC update; decoder outcome only matters in EXEC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        icnt_d  = icnt_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (h) begin
                    state_d = S_HALT;
                end else begin
                    if (pcwe && !pcs) begin
                        pc_d = jt;
                    end else if (pcwe) begin
                        pc_d = pc_q + jt;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                    icnt_d  = icnt_q + CW'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
`ifdef HALT_RESUME_EN
                if (run) begin
                    pc_d    = pc_q + AW'(1);
                    icnt_d  = icnt_q + CW'(1);
                    state_d = S_FETCH;
                end
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Request is gated by rst_n so it drops the moment reset asserts
    assign imem_req  = rst_n && (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst_vld  = (state_q == S_EXEC);
    assign o         = (state_q == S_EXEC) ? ir_q : '0;
    assign halted    = (state_q == S_HALT);
    assign icnt      = icnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written wait/reset/resume sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] o;
    logic        inst_vld;
    logic [15:0] pc;
    logic        h = 1'b0;
    logic        pcwe = 1'b0;
    logic        pcs = 1'b0;
    logic [15:0] jt = '0;
    logic        halted;
    logic [15:0] icnt;
`ifdef HALT_RESUME_EN
    logic        run = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    fetch_unit #(.AW(16), .IW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .o(o), .inst_vld(inst_vld), .pc(pc),
        .h(h), .pcwe(pcwe), .pcs(pcs), .jt(jt),
        .halted(halted), .icnt(icnt)
`ifdef HALT_RESUME_EN
        , .run(run)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        logic        ack;
        logic [15:0] data;
        logic        h, pcwe, pcs;
        logic [15:0] jt;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_o;
        logic        e_vld;
        logic        e_halted;
        logic [15:0] e_icnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input logic a, input logic [15:0] d,
                       input logic hh, input logic we, input logic s, input logic [15:0] j,
                       input logic req, input logic [15:0] addr, input logic [15:0] oo,
                       input logic vld, input logic hl, input logic [15:0] ic);
        vec_t v;
        v.rst_before = r; v.ack = a; v.data = d; v.h = hh; v.pcwe = we; v.pcs = s; v.jt = j;
        v.e_req = req; v.e_addr = addr; v.e_o = oo; v.e_vld = vld; v.e_halted = hl; v.e_icnt = ic;
        vecs.push_back(v);
    endtask

    task automatic idle();
        imem_ack = 1'b0; imem_data = '0; h = 1'b0; pcwe = 1'b0; pcs = 1'b0; jt = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset for one edge, checks reset values, releases just after an edge
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'(1'b0));
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_vld", 32'(inst_vld), 32'(1'b0));
        chk("rst_halted", 32'(halted), 32'(1'b0));
        chk("rst_icnt", 32'(icnt), 32'h0);
        chk("rst_o", 32'(o), 32'h0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Sequential fetch, zero wait; third word is treated as HALT by the decoder
        add(1, 1, 16'h0400, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'd0);
        add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0400, 1, 0, 16'd0);
        add(0, 1, 16'h0501, 0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 0, 0, 16'd1);
        add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0501, 1, 0, 16'd1);
        add(0, 1, 16'h0001, 0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0000, 0, 0, 16'd2);
        add(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0002, 16'h0001, 1, 0, 16'd2);
        add(0, 1, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 16'h0002, 16'h0000, 0, 1, 16'd2);
        add(0, 0, 16'h0000, 0, 1, 0, 16'h0055, 0, 16'h0002, 16'h0000, 0, 1, 16'd2);
        // Jumps, relative branch, wrap, halt-over-pcwe priority
        add(1, 1, 16'h1111, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'd0);
        add(0, 0, 16'h0000, 0, 1, 0, 16'h0010, 0, 16'h0000, 16'h1111, 1, 0, 16'd0);
        add(0, 1, 16'h2222, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0000, 0, 0, 16'd1);
        add(0, 0, 16'h0000, 0, 1, 0, 16'h0040, 0, 16'h0010, 16'h2222, 1, 0, 16'd1);
        add(0, 1, 16'h3333, 0, 0, 0, 16'h0000, 1, 16'h0040, 16'h0000, 0, 0, 16'd2);
        add(0, 0, 16'h0000, 0, 1, 0, 16'h0010, 0, 16'h0040, 16'h3333, 1, 0, 16'd2);
        add(0, 1, 16'h4444, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0000, 0, 0, 16'd3);
        add(0, 0, 16'h0000, 0, 1, 1, 16'hFFFE, 0, 16'h0010, 16'h4444, 1, 0, 16'd3);
        add(0, 1, 16'h5555, 0, 0, 0, 16'h0000, 1, 16'h000E, 16'h0000, 0, 0, 16'd4);
        add(0, 0, 16'h0000, 0, 1, 0, 16'hFFFF, 0, 16'h000E, 16'h5555, 1, 0, 16'd4);
        add(0, 1, 16'h6666, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0000, 0, 0, 16'd5);
        add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 16'h6666, 1, 0, 16'd5);
        add(0, 1, 16'h7777, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'd6);
        add(0, 0, 16'h0000, 1, 1, 0, 16'h0123, 0, 16'h0000, 16'h7777, 1, 0, 16'd6);
        add(0, 1, 16'h8888, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'd6);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            imem_ack = vecs[i].ack; imem_data = vecs[i].data;
            h = vecs[i].h; pcwe = vecs[i].pcwe; pcs = vecs[i].pcs; jt = vecs[i].jt;
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_o", i), 32'(o), 32'(vecs[i].e_o));
            chk($sformatf("v%0d_vld", i), 32'(inst_vld), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halted));
            chk($sformatf("v%0d_icnt", i), 32'(icnt), 32'(vecs[i].e_icnt));
            tick();
        end

`ifndef HALT_RESUME_EN
        // Without the resume feature HALT is sticky
        idle();
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stay_halted", 32'(halted), 32'(1'b1));
            chk("stay_noreq", 32'(imem_req), 32'(1'b0));
            tick();
        end
`endif

        // Wait states: ack arrives on the 4th FETCH cycle, EXEC in cycle 5
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            imem_ack = (c == 4); imem_data = 16'h0ABC;
            #1;
            chk($sformatf("ws%0d_req", c), 32'(imem_req), 32'(1'b1));
            chk($sformatf("ws%0d_addr", c), 32'(imem_addr), 32'h0);
            chk($sformatf("ws%0d_o", c), 32'(o), 32'h0);
            chk($sformatf("ws%0d_vld", c), 32'(inst_vld), 32'(1'b0));
            tick();
        end
        idle();
        #1;
        chk("ws5_vld", 32'(inst_vld), 32'(1'b1));
        chk("ws5_o", 32'(o), 32'h0ABC);
        tick();

        // Reset while FETCH waits at pc = 5
        do_reset();
        imem_ack = 1'b1; imem_data = 16'h0123;
        tick();
        idle();
        pcwe = 1'b1; jt = 16'h0005;
        tick();
        idle();
        #1;
        chk("mf_req", 32'(imem_req), 32'(1'b1));
        chk("mf_addr", 32'(imem_addr), 32'h5);
        chk("mf_icnt", 32'(icnt), 32'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mf_req_drop", 32'(imem_req), 32'(1'b0));
        chk("mf_addr_rst", 32'(imem_addr), 32'h0);
        chk("mf_icnt_rst", 32'(icnt), 32'h0);
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b1; imem_data = 16'h0777;
        #1;
        chk("mf_restart_req", 32'(imem_req), 32'(1'b1));
        chk("mf_restart_addr", 32'(imem_addr), 32'h0);
        chk("mf_restart_icnt", 32'(icnt), 32'h0);
        tick();
        idle();
        #1;
        chk("mf_restart_o", 32'(o), 32'h0777);
        tick();

`ifdef HALT_RESUME_EN
        // Halt at pc = 7, then resume with a run pulse
        do_reset();
        imem_ack = 1'b1; imem_data = 16'h1000;
        tick();
        idle();
        pcwe = 1'b1; jt = 16'h0007;
        tick();
        idle();
        imem_ack = 1'b1; imem_data = 16'h0001;
        tick();
        idle();
        h = 1'b1;
        tick();
        idle();
        #1;
        chk("rs_halted", 32'(halted), 32'(1'b1));
        chk("rs_pc", 32'(pc), 32'h7);
        chk("rs_icnt", 32'(icnt), 32'h1);
        run = 1'b1;
        tick();
        run = 1'b0;
        #1;
        chk("rs_resumed", 32'(halted), 32'(1'b0));
        chk("rs_req", 32'(imem_req), 32'(1'b1));
        chk("rs_addr", 32'(imem_addr), 32'h8);
        chk("rs_icnt2", 32'(icnt), 32'h2);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage of the PU. It owns the PC, fetches one 16-bit instruction word per step from instruction memory over a req/ack handshake, and holds it in an instruction register. During a one-cycle execute window it presents the word to the decoder. It then applies the decoder's halt, pcwe and pcs outcome to form the next PC.

## Interface
Parameters:
- AW, 16, PC / instruction-memory address width
- IW, 16, instruction width; must equal decoder opcode width (`CMDS+1`)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  AW  fetch address; always equals pc
- imem_ack  input  1  memory has valid imem_data this cycle
- imem_data  input  IW  instruction word
- o  output  IW  instruction to decoder
- inst_vld  output  1  high in the execute cycle
- pc  output  AW  address of the instruction in ir
- h  input  1  halt, from decoder
- pcwe  input  1  PC write enable, from decoder
- pcs  input  1  PC-relative select, from decoder
- jt  input  AW  jump value (ALU result / immediate path)
- halted  output  1  HALT state indicator
- icnt  output  16  retired-instruction counter
- run  input  1  resume pulse (present only with HALT_RESUME_EN)

## Operation
- States: FETCH, EXEC, HALT.
- Reset (asynchronous, rst_n low) sets:
  - state = FETCH
  - pc = 0, ir = 0, icnt = 0
  - imem_req = 0 while rst_n is low
  - halted = 0, inst_vld = 0
- FETCH:
  - imem_req = 1, held until an ack.
  - On imem_ack, ir <= imem_data and the state goes to EXEC.
  - No ack keeps the state in FETCH (wait states, unbounded).
  - imem_addr stays stable while the request is pending.
- EXEC:
  - inst_vld = 1, o = ir.
  - At the clock edge, priority from highest to lowest:
    - h = 1: state goes to HALT; pc and icnt are unchanged.
    - pcwe = 1, pcs = 0: pc <= jt.
    - pcwe = 1, pcs = 1: pc <= pc + jt, truncated to AW bits (jt is two's complement, so backward branches work).
    - Otherwise: pc <= pc + 1.
  - For every non-halt case, icnt <= icnt + 1 and the state goes to FETCH.
- Outside EXEC, o = 16'h0000 (NOP). The decoder therefore negates we, dmwe and pcwe. h, pcwe and pcs are ignored outside EXEC.
- HALT:
  - halted = 1, imem_req = 0, o = NOP.
  - pc holds the address of the HALT instruction.
- Arithmetic: pc wraps from 2^AW−1 to 0. icnt wraps from 16'hFFFF to 0.
- imem_ack outside FETCH is ignored; imem_data is never sampled.
- Reset in any state, including a pending FETCH, aborts immediately: imem_req drops asynchronously and no partial instruction is retired.

## Timing
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction (FETCH, EXEC).
- Each extra cycle before imem_ack adds one cycle.
- The decoder and datapath are combinational from o in the EXEC cycle. Register-file, data-memory and PC writes all commit at the EXEC→FETCH edge.
- The new pc is visible on imem_addr in the first FETCH cycle that follows.
- halted rises in the cycle after the EXEC of a HALT instruction.
- All outputs are registered or decoded from state only; there is no combinational path from imem_ack to o.

## Configuration
- HALT_RESUME_EN defined:
  - run port exists.
  - run = 1 in HALT sets pc <= pc + 1, increments icnt, and moves to FETCH.
  - run is ignored in other states.
- HALT_RESUME_EN undefined:
  - No run port.
  - HALT is exited only by rst_n.

## Test plan
- Sequential fetch: memory returns 0x0400, 0x0501, 0x0001 with zero wait.
  - imem_addr = 0, 1, 2 at 2-cycle spacing.
  - halted = 1 after the third EXEC; icnt = 2; pc = 2.
- Wait states: imem_ack delayed 3 cycles on address 0.
  - imem_req held 4 cycles with imem_addr = 0; o = 0 throughout.
  - EXEC occurs in cycle 5.
- Jumps:
  - In EXEC with pc = 0x0010, pcwe = 1, pcs = 0, jt = 0x0040: next imem_addr = 0x0040.
  - With pcs = 1, jt = 0xFFFE: next imem_addr = 0x000E.
- Priority and wrap:
  - h = 1 together with pcwe = 1 in EXEC: HALT entered, pc unchanged.
  - pc = 0xFFFF, plain EXEC: next pc = 0x0000.
- Reset mid-fetch: assert rst_n low while FETCH is waiting on ack at pc = 5.
  - imem_req drops immediately.
  - After release, fetch restarts at address 0 with icnt = 0.
- HALT_RESUME_EN: run pulse in HALT at pc = 7.
  - halted falls; next imem_addr = 8.
  - Without the macro, run is absent and the unit stays halted.
